// File: rtl/uart_receiver_control_fsm.sv
// UART receive sequencer: detects the start bit, times the three mid-bit votes
// from the oversample tick and steps the receive shift register through one frame.
module uart_receiver_control_fsm #(
    parameter int OVERSAMPLE   = 16,
    parameter int START_OFFSET = 2
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       rx_en,
    input  logic       baud_tick,
    input  logic       rx_data,
    input  logic       frame_error,
    input  logic       all_zero,
    input  logic [1:0] wls,
    input  logic       pen,
    output logic       voting_shift_en,
    output logic       receive_shift_en,
    output logic       error_check,
    output logic       rx_done,
    output logic       rx_break,
    output logic       rx_busy
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] VOTE_FIRST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] VOTE_LAST  = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_OFFSET);
    // Shifts left after the start bit: 5 base data bits plus the stop bit.
    localparam logic [3:0]       BIT_BASE   = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_CHECK,
        S_LINE_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       wls_q, wls_d;
    logic             pen_q, pen_d;
    logic             third_vote_q, third_vote_d;
    logic             decide_q, decide_d;
    logic             settle_q, settle_d;
    logic             voting_shift_en_q, voting_shift_en_d;
    logic             receive_shift_en_q, receive_shift_en_d;
    logic             error_check_q, error_check_d;
    logic             rx_done_q, rx_done_d;
    logic             rx_break_q, rx_break_d;
    logic             rx_busy_q, rx_busy_d;

    logic             in_vote;
    logic [CNT_W-1:0] tick_inc;

    assign in_vote  = (tick_cnt_q >= VOTE_FIRST) && (tick_cnt_q <= VOTE_LAST);
    assign tick_inc = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;

    always_comb begin
        state_d            = state_q;
        tick_cnt_d         = tick_cnt_q;
        bit_cnt_d          = bit_cnt_q;
        wls_d              = wls_q;
        pen_d              = pen_q;
        third_vote_d       = 1'b0;
        // rx_data reflects a vote one cycle after the voting register shifts.
        decide_d           = third_vote_q;
        settle_d           = voting_shift_en_q;
        voting_shift_en_d  = 1'b0;
        receive_shift_en_d = 1'b0;
        error_check_d      = 1'b0;
        rx_done_d          = 1'b0;
        rx_break_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                voting_shift_en_d = baud_tick;
                if (settle_q && rx_en && !rx_data) begin
                    state_d    = S_START;
                    tick_cnt_d = START_LOAD;
                    wls_d      = wls;
                    pen_d      = pen;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    tick_cnt_d        = tick_inc;
                    voting_shift_en_d = in_vote;
                    third_vote_d      = (tick_cnt_q == VOTE_LAST);
                end
                if (decide_q) begin
                    if (rx_data) begin
                        state_d = S_IDLE;
                    end else begin
                        receive_shift_en_d = 1'b1;
                        bit_cnt_d          = BIT_BASE + {2'b00, wls_q} + {3'b000, pen_q};
                        state_d            = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    tick_cnt_d        = tick_inc;
                    voting_shift_en_d = in_vote;
                    third_vote_d      = (tick_cnt_q == VOTE_LAST);
                end
                if (decide_q) begin
                    receive_shift_en_d = 1'b1;
                    bit_cnt_d          = bit_cnt_q - 4'd1;
                end else if (bit_cnt_q == 4'd0) begin
                    // This is the stop-bit shift cycle; flag the check for the next one.
                    state_d       = S_CHECK;
                    error_check_d = 1'b1;
                    rx_done_d     = 1'b1;
                end
            end
            S_CHECK: begin
                rx_break_d = frame_error && all_zero;
                state_d    = frame_error ? S_LINE_WAIT : S_IDLE;
            end
            S_LINE_WAIT: begin
                if (baud_tick) begin
                    tick_cnt_d        = tick_inc;
                    voting_shift_en_d = 1'b1;
                end
                // Hold off until the line is seen high so a held break cannot re-trigger.
                if (settle_q && rx_data) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q            <= S_IDLE;
            tick_cnt_q         <= '0;
            bit_cnt_q          <= '0;
            wls_q              <= '0;
            pen_q              <= 1'b0;
            third_vote_q       <= 1'b0;
            decide_q           <= 1'b0;
            settle_q           <= 1'b0;
            voting_shift_en_q  <= 1'b0;
            receive_shift_en_q <= 1'b0;
            error_check_q      <= 1'b0;
            rx_done_q          <= 1'b0;
            rx_break_q         <= 1'b0;
            rx_busy_q          <= 1'b0;
        end else begin
            state_q            <= state_d;
            tick_cnt_q         <= tick_cnt_d;
            bit_cnt_q          <= bit_cnt_d;
            wls_q              <= wls_d;
            pen_q              <= pen_d;
            third_vote_q       <= third_vote_d;
            decide_q           <= decide_d;
            settle_q           <= settle_d;
            voting_shift_en_q  <= voting_shift_en_d;
            receive_shift_en_q <= receive_shift_en_d;
            error_check_q      <= error_check_d;
            rx_done_q          <= rx_done_d;
            rx_break_q         <= rx_break_d;
            rx_busy_q          <= rx_busy_d;
        end
    end

    assign voting_shift_en  = voting_shift_en_q;
    assign receive_shift_en = receive_shift_en_q;
    assign error_check      = error_check_q;
    assign rx_done          = rx_done_q;
    assign rx_break         = rx_break_q;
    assign rx_busy          = rx_busy_q;

endmodule
